shifter_mc: RTL

- Parametrised multicycle barrel-lite shifter for the micro-coded datapath. Successor to the 3-position-per-cycle shifter.
- Generalises the per-cycle step to a STEP parameter and adds rotate-left and rotate-right modes.
- Owns an internal result register and a start/busy/done handshake, so the caller does not need to recirculate the value.
- Right shifts cost no extra cycle.

---
 rtl/shifter_mc.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/shifter_mc.sv
// Multicycle shifter: shifts or rotates an operand by up to STEP positions per
// cycle. The result is held in an internal register, and a start/busy/done
// handshake controls each operation.
//
// Ports:
//   clk          clock
//   rst          synchronous active-high reset
//   start        request, accepted only while busy=0
//   val_i        operand, sampled on the accepted start
//   sham_i       shift amount, sampled on the accepted start
//   op_i         00=SLL 01=SRL 10=SRA 11=ROT, sampled on the accepted start
//   rot_right_i  ROT direction (0=left, 1=right), sampled on the accepted start
//   busy         operation in progress
//   done         one-cycle pulse; val_o holds the result in the same cycle
//   val_o        result register, held until the next accepted start
module shifter_mc #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned STEP  = 3
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [WIDTH-1:0]         val_i,
   input  logic [$clog2(WIDTH)-1:0] sham_i,
   input  logic [1:0]               op_i,
   input  logic                     rot_right_i,
   output logic                     busy,
   output logic                     done,
   output logic [WIDTH-1:0]         val_o
);

   localparam int unsigned WSHAM = $clog2(WIDTH);
   localparam int unsigned WAMT  = $clog2(STEP + 1);
   localparam logic [WSHAM-1:0] STEP_W = WSHAM'(STEP);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   typedef enum logic [1:0] {
      OP_SLL = 2'b00,
      OP_SRL = 2'b01,
      OP_SRA = 2'b10,
      OP_ROT = 2'b11
   } op_t;

   state_t           state, state_nx;
   logic             busy_nx, done_nx;
   logic [WIDTH-1:0] val_nx;
   logic [WSHAM-1:0] rem, rem_nx;
   op_t              op_q, op_nx;
   logic             dir_q, dir_nx;
   logic             fill_q, fill_nx;

   // Operands of the shared step shifter
   logic [WIDTH-1:0] src;
   logic [WSHAM-1:0] rem_src;
   op_t              src_op;
   logic             src_dir;
   logic             src_fill;
   logic [WSHAM-1:0] amt_full;
   logic [WAMT-1:0]  amt;
   logic [WSHAM-1:0] rem_after;
   logic [WIDTH-1:0] shifted;

   // One STEP+1 input mux per bit: selects the operand shifted by 0..STEP
   function automatic logic [WIDTH-1:0] step_shift(
      input logic [WIDTH-1:0] v,
      input logic [WAMT-1:0]  a,
      input op_t              o,
      input logic             dir,
      input logic             fill
   );
      logic [WIDTH-1:0] r;
      r = v;
      for (int unsigned k = 1; k <= STEP; k++) begin
         if (a == WAMT'(k)) begin
            case (o)
               OP_SLL:  r = v << k;
               OP_SRL:  r = v >> k;
               // top k bits come from the latched sign, not from the shifting register
               OP_SRA:  r = (v >> k) | (~({WIDTH{1'b1}} >> k) & {WIDTH{fill}});
               default: r = dir ? ((v >> k) | (v << (WIDTH - k)))
                                : ((v << k) | (v >> (WIDTH - k)));
            endcase
         end
      end
      return r;
   endfunction

   // Operand select: new request while idle, latched context while running
   always_comb begin
      if (state == IDLE) begin
         src      = val_i;
         rem_src  = sham_i;
         src_op   = op_t'(op_i);
         src_dir  = rot_right_i;
         src_fill = val_i[WIDTH-1];
      end else begin
         src      = val_o;
         rem_src  = rem;
         src_op   = op_q;
         src_dir  = dir_q;
         src_fill = fill_q;
      end
      amt_full  = (rem_src > STEP_W) ? STEP_W : rem_src;
      amt       = WAMT'(amt_full);
      rem_after = rem_src - amt_full;
      shifted   = step_shift(src, amt, src_op, src_dir, src_fill);
   end

   // Next-state and next-output logic
   always_comb begin
      state_nx = state;
      done_nx  = 1'b0;
      val_nx   = val_o;
      rem_nx   = rem;
      op_nx    = op_q;
      dir_nx   = dir_q;
      fill_nx  = fill_q;
      case (state)
         IDLE: begin
            if (start) begin
               val_nx  = shifted;
               rem_nx  = rem_after;
               op_nx   = src_op;
               dir_nx  = src_dir;
               fill_nx = src_fill;
               if (rem_after == '0) begin
                  done_nx = 1'b1;
               end else begin
                  state_nx = RUN;
               end
            end
         end
         RUN: begin
            val_nx = shifted;
            rem_nx = rem_after;
            if (rem_after == '0) begin
               state_nx = IDLE;
               done_nx  = 1'b1;
            end
         end
         default: state_nx = IDLE;
      endcase
      busy_nx = (state_nx == RUN);
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         busy   <= 1'b0;
         done   <= 1'b0;
         val_o  <= '0;
         rem    <= '0;
         op_q   <= OP_SLL;
         dir_q  <= 1'b0;
         fill_q <= 1'b0;
      end else begin
         state  <= state_nx;
         busy   <= busy_nx;
         done   <= done_nx;
         val_o  <= val_nx;
         rem    <= rem_nx;
         op_q   <= op_nx;
         dir_q  <= dir_nx;
         fill_q <= fill_nx;
      end
   end

endmodule
